// File: rtl/mnist_ctrl_pkg.sv
// mnist_ctrl_pkg: shared state encoding and network shape for the inference controller
package mnist_ctrl_pkg;
  localparam int NUM_LAYERS = 3;
  localparam int FAN_IN [NUM_LAYERS] = '{784, 20, 20};
  typedef enum logic [2:0] {IDLE, CLEAR, ACCUM, ACT, WAIT_ACT, FINAL, DONE} state_t;
endpackage

// File: rtl/ctrl_counter.sv
// ctrl_counter: up-counter with synchronous clear/enable and terminal-count flag
module ctrl_counter #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] last,
  output logic [W-1:0] q,
  output logic         tc
);
  always_ff @(posedge clk) q <= (!rst || clr) ? '0 : en ? q + 1'b1 : q;
  assign tc = en && q == last;
endmodule

// File: rtl/inference_sequencer.sv
// inference_sequencer: Moore FSM sequencing clear/accumulate/activate across the dense layers.
// Define CTRL_TIMEOUT_EN to bound WAIT_ACT and raise a sticky timeout error.
module inference_sequencer
  import mnist_ctrl_pkg::*;
#(
  parameter int NUM_LAYERS     = mnist_ctrl_pkg::NUM_LAYERS,
  parameter int IDX_W          = 10,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          abort,
  input  logic                          relu_done,
  output logic                          busy,
  output logic                          mac_clr,
  output logic                          mac_en,
  output logic [IDX_W-1:0]              mac_idx,
  output logic [$clog2(NUM_LAYERS)-1:0] layer_idx,
  output logic                          relu_valid,
  output logic                          argmax_valid,
  output logic                          done,
  output logic                          error
);
  localparam int LW = $clog2(NUM_LAYERS);
  state_t state;
  logic tc;
  logic [IDX_W-1:0] last_idx;
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end
  assign last_idx = IDX_W'(FAN_IN[layer_idx] - 1);
  // The index is held at zero everywhere except ACCUM, and wraps to zero on the last step or an abort.
  ctrl_counter #(.W(IDX_W)) u_mac_cnt (
    .clk (clk),
    .rst (rst),
    .clr (state != ACCUM || tc || abort),
    .en  (state == ACCUM),
    .last(last_idx),
    .q   (mac_idx),
    .tc  (tc)
  );
`ifdef CTRL_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo;
`else
  assign error = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      layer_idx <= '0;
`ifdef CTRL_TIMEOUT_EN
      error <= 1'b0;
      tmo <= '0;
`endif
    end else if (abort && state != IDLE) begin
      state <= IDLE;
      layer_idx <= '0;
    end else begin
`ifdef CTRL_TIMEOUT_EN
      tmo <= '0;
`endif
      case (state)
        IDLE: if (start) begin
          state <= CLEAR;
          layer_idx <= '0;
`ifdef CTRL_TIMEOUT_EN
          error <= 1'b0;
`endif
        end
        CLEAR: state <= ACCUM;
        ACCUM: if (tc) state <= layer_idx == LW'(NUM_LAYERS - 1) ? FINAL : ACT;
        ACT: state <= WAIT_ACT;
        WAIT_ACT: if (relu_done) begin
          state <= CLEAR;
          layer_idx <= layer_idx + 1'b1;
        end
`ifdef CTRL_TIMEOUT_EN
        else if (tmo == TW'(TIMEOUT_CYCLES - 1)) begin
          state <= IDLE;
          error <= 1'b1;
        end else tmo <= tmo + 1'b1;
`endif
        FINAL: state <= DONE;
        DONE: begin
          state <= IDLE;
          layer_idx <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end
  assign busy = state != IDLE;
  assign mac_clr = state == CLEAR;
  assign mac_en = state == ACCUM;
  assign relu_valid = state == ACT;
  assign argmax_valid = state == FINAL;
  assign done = state == DONE;
endmodule

// File: tb/tb_inference_sequencer.sv
// tb_inference_sequencer: randomized runs checked by a scoreboard against a per-run timing model.
module tb_inference_sequencer;
  logic clk = 0, rst = 0, start = 0, abort = 0, relu_done = 0;
  logic busy, mac_clr, mac_en, relu_valid, argmax_valid, done, error;
  logic [9:0] mac_idx;
  logic [1:0] layer_idx;
  int checks = 0, failures = 0, cyc = 0;
  localparam int FAN [3] = '{784, 20, 20};
  typedef struct {
    int end_t; bit done_exp; int done_t; int en0; int en1; int en2; int relu; int arg; bit err; bit zero;
  } exp_t;
  exp_t sb[$];
  exp_t em;

  inference_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .relu_done(relu_done),
    .busy(busy), .mac_clr(mac_clr), .mac_en(mac_en), .mac_idx(mac_idx), .layer_idx(layer_idx),
    .relu_valid(relu_valid), .argmax_valid(argmax_valid), .done(done), .error(error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // kind: 0 normal, 1 abort in ACCUM at (al,ai), 2 reset in first WAIT_ACT of layer al, 3 timeout in layer al.
  // Offsets are cycles after the cycle in which start was sampled; d = WAIT_ACT cycles until relu_done.
  function automatic exp_t model(input int kind, input int d0, input int d1, input int al, input int ai);
    exp_t r = '{default: 0};
    int en[3] = '{0, 0, 0};
    int d[2];
    int t = 1;
    int acc;
    d[0] = d0;
    d[1] = d1;
    for (int l = 0; l < 3; l++) begin
      acc = t + 1;
      if (kind == 1 && l == al) begin en[l] = ai + 1; r.end_t = acc + ai + 1; break; end
      en[l] = FAN[l];
      if (l == 2) begin r.arg = 1; r.done_exp = 1; r.done_t = acc + FAN[l] + 1; r.end_t = r.done_t + 1; break; end
      r.relu++;
      if (kind == 2 && l == al) begin r.zero = 1; r.end_t = acc + FAN[l] + 2; break; end
      if (kind == 3 && l == al) begin r.err = 1; r.end_t = acc + FAN[l] + 1 + 16; break; end
      t = acc + FAN[l] + 1 + d[l];
    end
    r.en0 = en[0];
    r.en1 = en[1];
    r.en2 = en[2];
    return r;
  endfunction

  bit prev_busy = 0;
  int t0 = 0, relu_cnt = 0, arg_cnt = 0, done_cnt = 0, done_at = 0, idx_bad = 0;
  int en_cnt[3];
  always @(negedge clk) begin
    if (busy && !prev_busy) begin
      t0 = cyc - 1;
      en_cnt = '{0, 0, 0};
      relu_cnt = 0; arg_cnt = 0; done_cnt = 0; done_at = 0; idx_bad = 0;
      chk("run_expected", int'(sb.size() > 0), 1);
      chk("error_clear_on_start", int'(error), 0);
    end
    if (busy) begin
      if (mac_en) begin
        if (layer_idx > 2 || int'(mac_idx) != en_cnt[layer_idx]) idx_bad++;
        else en_cnt[layer_idx]++;
      end else if (mac_idx != 0) idx_bad++;
      relu_cnt += int'(relu_valid);
      arg_cnt += int'(argmax_valid);
      if (done) begin done_cnt++; done_at = cyc - t0; end
    end else if (prev_busy) begin
      chk("sb_pending", sb.size(), 1);
      if (sb.size() > 0) begin
        em = sb.pop_front();
        chk("end_cycle", cyc - t0, em.end_t);
        chk("done_count", done_cnt, int'(em.done_exp));
        if (em.done_exp) chk("done_latency", done_at, em.done_t);
        chk("mac_en_l0", en_cnt[0], em.en0);
        chk("mac_en_l1", en_cnt[1], em.en1);
        chk("mac_en_l2", en_cnt[2], em.en2);
        chk("relu_valid_count", relu_cnt, em.relu);
        chk("argmax_count", arg_cnt, em.arg);
        chk("error_flag", int'(error), int'(em.err));
        chk("mac_idx_sequence", idx_bad, 0);
        if (em.zero) chk("reset_outputs",
          int'({mac_clr, mac_en, relu_valid, argmax_valid, done, error, mac_idx, layer_idx}), 0);
      end
    end
    prev_busy = busy;
  end

  task automatic run(input int kind, input int d0, input int d1, input int al, input int ai,
                     input bit noise, input bit hold);
    int cd = 0, cur = 0, n = 0;
    sb.push_back(model(kind, d0, d1, al, ai));
    start = 1;
    @(posedge clk); #1;
    if (!hold) start = 0;
    while (busy && n < 3000) begin
      relu_done = 0; abort = 0; rst = 1;
      if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          if (kind == 2 && cur == al) rst = 0;
          else if (!(kind == 3 && cur == al)) relu_done = 1;
        end
      end
      if (relu_valid) begin
        cur = int'(layer_idx);
        cd = (kind == 2 && cur == al) ? 1 : (cur == 0 ? d0 : d1);
      end
      if (noise && mac_en && $urandom_range(0, 3) == 0) relu_done = 1;
      if (kind == 1 && mac_en && int'(layer_idx) == al && int'(mac_idx) == ai) abort = 1;
      @(posedge clk); #1;
      n++;
    end
    chk("run_bounded", int'(n < 3000), 1);
    relu_done = 0; abort = 0; rst = 1; start = 0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 0; start = 1; abort = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", int'(busy), 0);
    chk("reset_all_outputs",
      int'({busy, mac_clr, mac_en, relu_valid, argmax_valid, done, error, mac_idx, layer_idx}), 0);
    rst = 1; start = 0; abort = 0;
    @(posedge clk); #1;
    chk("idle_after_reset", int'(busy), 0);
    run(0, 1, 1, 0, 0, 0, 0);
    run(1, 1, 1, 1, 5, 0, 0);
    run(0, 1, 1, 0, 0, 0, 0);
    run(0, $urandom_range(1, 4), $urandom_range(1, 4), 0, 0, 0, 1);
    run(2, 1, 1, 0, 0, 0, 0);
    relu_done = 1;
    @(posedge clk); #1;
    relu_done = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("relu_done_ignored_idle", int'(busy), 0);
    run(0, $urandom_range(1, 4), $urandom_range(1, 4), 0, 0, 1, 0);
    run(1, 1, 1, 2, 19, 1, 0);
    for (int i = 0; i < 3; i++) begin
      int al;
      al = $urandom_range(0, 2);
      run($urandom_range(0, 1), $urandom_range(1, 4), $urandom_range(1, 4), al,
          $urandom_range(0, FAN[al] - 1), 1'($urandom_range(0, 1)), 0);
    end
`ifdef CTRL_TIMEOUT_EN
    run(3, 1, 1, $urandom_range(0, 1), 0, 0, 0);
    run(0, 1, 1, 0, 0, 0, 0);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/inference_sequencer.md
INFERENCE_SEQUENCER -- requirements
Module: inference_sequencer

Interface
REQ-001 SHALL have parameter NUM_LAYERS, default 3: number of dense layers sequenced (784-20-20-10 network).
REQ-002 SHALL have parameter IDX_W, default 10: width of the MAC input-index counter.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 16: cycles allowed in WAIT_ACT (used only with the timeout feature).
REQ-004 SHALL have port clk, input, 1 bit: single clock; all logic on posedge.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous and active-low.
REQ-006 SHALL have port start, input, 1 bit: request one inference.
REQ-007 SHALL have port abort, input, 1 bit: cancel the inference in progress.
REQ-008 SHALL have port relu_done, input, 1 bit: o_valid returned by the ReLU layer.
REQ-009 SHALL have port busy, output, 1 bit: high in any state other than IDLE.
REQ-010 SHALL have port mac_clr, output, 1 bit: clear the dense-layer accumulators.
REQ-011 SHALL have port mac_en, output, 1 bit: accumulate one input this cycle.
REQ-012 SHALL have port mac_idx, output, IDX_W bits: input/weight index for the current MAC step.
REQ-013 SHALL have port layer_idx, output, $clog2(NUM_LAYERS) bits: current layer number.
REQ-014 SHALL have port relu_valid, output, 1 bit: drives the ReLU layer i_valid.
REQ-015 SHALL have port argmax_valid, output, 1 bit: final-layer scores are valid.
REQ-016 SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-017 SHALL have port error, output, 1 bit: sticky timeout flag.

Function
REQ-018 SHALL implement FSM states IDLE, CLEAR, ACCUM, ACT, WAIT_ACT, FINAL, DONE; outputs SHALL be decoded from the state register and the counters only (Moore).
REQ-019 SHALL, in IDLE, go to CLEAR with layer_idx=0 when start=1; start in any other state SHALL be ignored.
REQ-020 SHALL assert mac_clr only in CLEAR (exactly 1 cycle), then enter ACCUM with mac_idx=0.
REQ-021 SHALL assert mac_en in every ACCUM cycle, incrementing mac_idx by 1 per cycle from 0 to FAN_IN[layer_idx]-1; mac_idx SHALL be 0 outside ACCUM.
REQ-022 SHALL leave ACCUM after the cycle with mac_idx=FAN_IN[layer_idx]-1: to FINAL if layer_idx=NUM_LAYERS-1, otherwise to ACT.
REQ-023 SHALL assert relu_valid only in ACT (exactly 1 cycle), then enter WAIT_ACT.
REQ-024 SHALL, in WAIT_ACT, on relu_done=1 increment layer_idx and go to CLEAR; relu_done in any other state SHALL be ignored.
REQ-025 SHALL assert argmax_valid only in FINAL (1 cycle), then assert done only in DONE (1 cycle), then return to IDLE.
REQ-026 SHALL, for abort=1 in any non-IDLE state, enter IDLE on the next edge with no done or argmax_valid pulse; abort SHALL take priority over every other transition, including the last ACCUM step and relu_done.
REQ-027 SHALL give total latency 1 + sum over layers of FAN_IN, + 3 per non-final layer, + 2 final; for FAN_IN={784,20,20} with 1-cycle ReLU turnaround, done SHALL be high 833 cycles after the cycle in which start was sampled.
REQ-028 SHALL, when start=1 in the DONE cycle, ignore it; a new start is accepted only in IDLE.

Reset
REQ-029 SHALL, on rst=0 at a clock edge, enter IDLE with busy, mac_clr, mac_en, relu_valid, argmax_valid, done and error 0, and mac_idx and layer_idx 0; reset SHALL override abort and start, including mid-inference.

Configuration
REQ-030 SHALL, with CTRL_TIMEOUT_EN defined, count cycles in WAIT_ACT; on reaching TIMEOUT_CYCLES without relu_done it SHALL set error and enter IDLE with no done; error SHALL clear on the next accepted start or on reset.
REQ-031 SHALL, without CTRL_TIMEOUT_EN, tie error to 0, contain no timeout counter, and wait in WAIT_ACT indefinitely.

Structure
REQ-032 SHALL take from the shared package mnist_ctrl_pkg: the state enum typedef, NUM_LAYERS, and the FAN_IN constant array {784,20,20}.
REQ-033 SHALL instantiate one sub-module, ctrl_counter (parameterised up-counter with clear, enable and terminal-count output), for mac_idx.

Verification
REQ-034 SHALL cover: start pulse with relu_done returned 1 cycle after each relu_valid -> exactly 784/20/20 mac_en cycles, 2 relu_valid pulses, and done at cycle 833.
REQ-035 SHALL cover: abort in ACCUM of layer 1 at mac_idx=5 -> IDLE next cycle, busy=0, no done; a following start completes normally in 833 cycles.
REQ-036 SHALL cover: start held high throughout an inference -> a single inference, done once, new run begins only from IDLE.
REQ-037 SHALL cover: rst=0 asserted in WAIT_ACT -> all outputs 0 next cycle; relu_done arriving afterwards is ignored.
REQ-038 SHALL cover: with CTRL_TIMEOUT_EN, relu_done withheld -> error=1 after 16 WAIT_ACT cycles, IDLE, no done; the next start clears error.
REQ-039 SHALL cover: relu_done pulsed during ACCUM -> no effect on mac_idx or state.
